// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for instr_encoder.
// master: request producer plus memory (drives requests and imem_ready).
// slave:  the encoder (accepts requests and drives the write port).
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [20:0] in_imm;
    logic        in_last;

    logic        imem_we;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Purpose: encodes structured RV32I requests into machine words and writes them
//          sequentially to instruction memory starting at BASE_ADDR.
// Latency: 1 cycle from request accept to imem_we; 1 word/cycle sustained.
// Backpressure: in_ready drops while a written word waits on imem_ready; the
//          pending word (we/addr/wdata) is held stable until the handshake.
// Ports: clk, reset (sync, active high), start; bus.slave carries the request
//          channel (in_*) and write port (imem_*); busy/done/err/count status.
// Optional: define ENC_RANGE_CHECK_EN to drop words whose immediate does not
//          fit the instruction format (sets err); otherwise immediates truncate.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    instr_encoder_if.slave                 bus,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(MAX_WORDS+1)-1:0] count
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW:0] MAX_V = MAX_WORDS[CW:0];

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          pend_last;   // the word waiting on imem_ready closes the program
    logic          last_seen;   // last request taken; refuse anything further
    logic [CW-1:0] count_q;
    logic          err_q;

    logic          accept;
    logic          handshake;
    logic          kind_ok;
    logic          imm_ok;
    logic          full;
    logic          write_ok;
    logic [31:0]   enc_word;
    logic [CW:0]   occ;

    assign handshake      = we_q & bus.imem_ready;
    assign bus.in_ready   = (state == LOAD) & ~last_seen & (~we_q | bus.imem_ready);
    assign accept         = bus.in_valid & bus.in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state == LOAD);
    assign done           = (state == DONE);
    assign err            = err_q;
    assign count          = count_q;

    // Words committed so far including the one still pending; a handshake this
    // cycle moves one from pending to written, so the total is unaffected.
    assign occ      = {1'b0, count_q} + {{CW{1'b0}}, we_q};
    assign full     = (occ >= MAX_V);
    assign write_ok = kind_ok & imm_ok & ~full;

    always_comb begin
        enc_word = '0;
        kind_ok  = 1'b1;
        imm_ok   = 1'b1;
        case (bus.in_kind)
            4'd0:  enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
            4'd1:  enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010,
                               bus.in_imm[4:0], 7'b0100011};
            4'd2:  enc_word = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
            4'd3:  enc_word = {7'b0100000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
            4'd4:  enc_word = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b111, bus.in_rd, 7'b0110011};
            4'd5:  enc_word = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b110, bus.in_rd, 7'b0110011};
            4'd6:  enc_word = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b010, bus.in_rd, 7'b0110011};
            4'd7:  enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                               bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
            4'd8:  enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b001,
                               bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
            4'd9:  enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011};
            4'd10: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                               bus.in_imm[19:12], bus.in_rd, 7'b1101111};
            default: kind_ok = 1'b0;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        // Signed fit: every bit above the format's sign bit must copy it.
        case (bus.in_kind)
            4'd0, 4'd1, 4'd9: imm_ok = (bus.in_imm[20:11] == {10{bus.in_imm[11]}});
            4'd7, 4'd8:       imm_ok = (bus.in_imm[20:12] == {9{bus.in_imm[12]}}) & ~bus.in_imm[0];
            4'd10:            imm_ok = ~bus.in_imm[0];
            default:          imm_ok = 1'b1;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            pend_last <= 1'b0;
            last_seen <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        addr_q    <= BASE_ADDR;
                        count_q   <= '0;
                        err_q     <= 1'b0;
                        last_seen <= 1'b0;
                        pend_last <= 1'b0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        we_q    <= 1'b0;
                        addr_q  <= addr_q + 32'd4;
                        count_q <= count_q + CW'(1);
                        if (pend_last) begin
                            state <= DONE;
                        end
                    end
                    // last_seen blocks accept, so this never overlaps a
                    // handshake of a last-tagged word.
                    if (accept) begin
                        if (bus.in_last) begin
                            last_seen <= 1'b1;
                        end
                        if (write_ok) begin
                            we_q      <= 1'b1;
                            wdata_q   <= enc_word;
                            pend_last <= bus.in_last;
                        end else begin
                            err_q <= 1'b1;
                            if (bus.in_last) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MW   = 16;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done, err;
    logic [$clog2(MW+1)-1:0] count;

    instr_encoder_if bus();

    instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        expq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_acc;      // words the model expects to be written this program
    bit          exp_err;
    bit          rand_rdy = 0;
    bit          use_lit = 0;
    logic [31:0] lit_word;
    bit          acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoding built field by field with shifts and masks.
    function automatic logic [31:0] ref_enc(int kind, int rd, int rs1, int rs2, int imm);
        int f3, f7, w;
        int r_f3[5] = '{0, 0, 7, 6, 2};
        w = 0;
        case (kind)
            0: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
            1: w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((imm & 'h1F) << 7) | 'h23;
            2, 3, 4, 5, 6: begin
                f3 = r_f3[kind - 2];
                f7 = (kind == 3) ? 'h20 : 0;
                w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            end
            7, 8: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                      | (rs1 << 15) | ((kind - 7) << 12) | (((imm >> 1) & 15) << 8)
                      | (((imm >> 11) & 1) << 7) | 'h63;
            9: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h13;
            default: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                         | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12)
                         | (rd << 7) | 'h6F;
        endcase
        return w;
    endfunction

    function automatic bit ref_imm_ok(int kind, int imm);
`ifdef ENC_RANGE_CHECK_EN
        if (kind == 0 || kind == 1 || kind == 9) return (imm >= -2048 && imm <= 2047);
        if (kind == 7 || kind == 8) return (imm >= -4096 && imm <= 4095 && imm % 2 == 0);
        if (kind == 10) return (imm % 2 == 0);
`endif
        return 1;
    endfunction

    task automatic model_accept();
        int kind, imm;
        exp_t e;
        kind = int'(bus.in_kind);
        imm  = $signed(bus.in_imm);
        if (kind > 10 || n_acc >= MW || !ref_imm_ok(kind, imm)) begin
            exp_err = 1;
        end else begin
            e.addr = BASE + 32'(4 * n_acc);
            e.data = use_lit ? lit_word
                             : ref_enc(kind, bus.in_rd, bus.in_rs1, bus.in_rs2, imm);
            expq.push_back(e);
            n_acc++;
        end
    endtask

    // Inputs change 1ns after posedge; the handshakes about to be captured are
    // observed at the falling edge.
    task automatic tick();
        exp_t e;
        if (rand_rdy) bus.imem_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (bus.imem_we === 1'b1 && bus.imem_ready === 1'b1) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL spurious_write: observed write %h@%h, expected no write",
                       bus.imem_wdata, bus.imem_addr);
            end else begin
                e = expq.pop_front();
                check("wr_addr", bus.imem_addr, e.addr);
                check("wr_data", bus.imem_wdata, e.data);
            end
        end
        acc = (bus.in_valid === 1'b1 && bus.in_ready === 1'b1);
        if (acc) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int kind, input int rd, input int rs1, input int rs2,
                        input int imm, input bit last, input bit lit_en,
                        input logic [31:0] lit, output int ticks);
        bus.in_valid = 1'b1;
        bus.in_kind  = 4'(kind);
        bus.in_rd    = 5'(rd);
        bus.in_rs1   = 5'(rs1);
        bus.in_rs2   = 5'(rs2);
        bus.in_imm   = 21'(imm);
        bus.in_last  = last;
        use_lit      = lit_en;
        lit_word     = lit;
        ticks = 0;
        acc   = 0;
        while (!acc && ticks < 60) begin
            tick();
            ticks++;
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $error("FAIL accept_timeout: observed no accept in %0d cycles, expected accept", ticks);
        end
        use_lit = 0;
    endtask

    task automatic sendr(input int kind, input int imm, input bit last);
        int t;
        send(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             imm, last, 0, 0, t);
    endtask

    task automatic do_start();
        bus.in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_acc   = 0;
        exp_err = 0;
    endtask

    task automatic finish_prog(input string tag);
        int k = 0;
        bus.in_valid = 1'b0;
        while (done !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_count"}, 32'(count), 32'(n_acc));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_next_addr"}, bus.imem_addr, BASE + 32'(4 * n_acc));
    endtask

    initial begin
        int t;
        int imm;
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 0; bus.in_kind = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
        bus.in_imm = 0; bus.in_last = 0; bus.imem_ready = 1'b1;
        n_acc = 0; exp_err = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_we", 32'(bus.imem_we), 0);
        check("rst_addr", bus.imem_addr, BASE);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(count), 0);
        reset = 1'b0;
        tick();

        // addi/add/sub program
        do_start();
        check("start_busy", 32'(busy), 1);
        send(9, 1, 0, 0, 5, 0, 1, 32'h0050_0093, t);
        send(2, 3, 1, 2, 0, 0, 1, 32'h0020_81B3, t);
        send(3, 3, 1, 2, 0, 1, 1, 32'h4020_81B3, t);
        finish_prog("prog_a");

        // loads, stores, branches, jal
        do_start();
        send(0, 2, 1, 0, 8, 0, 1, 32'h0080_A103, t);
        send(1, 0, 1, 2, 4, 0, 1, 32'h0020_A223, t);
        send(7, 0, 1, 2, -8, 0, 1, 32'hFE20_8CE3, t);
        send(8, 0, 1, 2, -8, 0, 1, 32'hFE20_9CE3, t);
        send(10, 1, 0, 0, 16, 1, 1, 32'h0100_00EF, t);
        finish_prog("prog_b");

        // backpressure: a word held while the next request waits
        do_start();
        bus.imem_ready = 1'b0;
        send(9, 1, 0, 0, 5, 0, 1, 32'h0050_0093, t);
        bus.in_kind = 4'd2; bus.in_rd = 5'd3; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(bus.in_ready), 0);
            check("stall_we", 32'(bus.imem_we), 1);
            check("stall_addr", bus.imem_addr, expq[0].addr);
            check("stall_wdata", bus.imem_wdata, expq[0].data);
            tick();
        end
        bus.imem_ready = 1'b1;
        send(2, 3, 1, 2, 0, 0, 0, 0, t);
        check("resume_lat", t, 1);
        send(3, 3, 1, 2, 0, 0, 0, 0, t);
        check("b2b_1", t, 1);
        send(5, 4, 5, 6, 0, 1, 0, 0, t);
        check("b2b_2", t, 1);
        finish_prog("stall");

        // unsupported kind mid-stream, then unsupported last
        do_start();
        sendr(4, 0, 0);
        sendr(12, 0, 0);
        send(9, 1, 0, 0, 2048, 0, 0, 0, t);
        sendr(6, 0, 0);
        sendr(13, 0, 1);
        check("unsup_last_done", 32'(done), 1);
        finish_prog("unsup");
        do_start();
        check("err_cleared", 32'(err), 0);
        // wide addi immediate: truncated (or rejected with range checks)
        send(9, 1, 0, 0, 2048, 1, 0, 0, t);
        finish_prog("imm2048");
`ifndef ENC_RANGE_CHECK_EN
        check("imm2048_word_count", 32'(count), 1);
`endif

        // capacity overflow
        do_start();
        for (int i = 0; i < MW + 2; i++) sendr(9, $urandom_range(0, 2047), i == MW + 1);
        finish_prog("capacity");

        // random programs with random backpressure and valid gaps
        rand_rdy = 1;
        for (int p = 0; p < 6; p++) begin
            int len = $urandom_range(3, 12);
            do_start();
            for (int i = 0; i < len; i++) begin
                int kind = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15)
                                                       : $urandom_range(0, 10);
                if ($urandom_range(0, 1) == 1) imm = $signed(21'($urandom));
                else imm = $urandom_range(0, 1000) * 2 - 1000;
                if ($urandom_range(0, 3) == 0) begin
                    bus.in_valid = 1'b0;
                    tick();
                end
                sendr(kind, imm, i == len - 1);
            end
            finish_prog("rand");
        end
        rand_rdy = 0;

        // reset with a word pending
        do_start();
        bus.imem_ready = 1'b0;
        sendr(2, 0, 0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expq.delete();
        check("midrst_we", 32'(bus.imem_we), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_addr", bus.imem_addr, BASE);
        check("midrst_in_ready", 32'(bus.in_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
